fruit_template_scorer: RTL and testbench

Streams one captured fruit feature frame against a template ROM and produces a sum-of-absolute-differences score plus a match flag. It sits directly downstream of the per-fruit template ROMs (pear, etc.): it drives the ROM address and consumes the ROM read data. The feature stream comes from the ISP feature extractor through a valid/ready handshake. The classifier compares scores across fruits.

---
 rtl/fruit_template_scorer.sv | 110 +++++++++++
 tb/tb_fruit_template_scorer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fruit_template_scorer.sv
// rtl/fruit_template_scorer.sv - streams a feature frame against a template ROM and produces a SAD score and match flag
// Optional TEMPLATE_SCORE_MASK_EN: an all-ones template byte is a don't-care and adds nothing to the score.
module fruit_template_scorer #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8,
    parameter int THRESH     = 16384
) (
    input  logic                            clk,
    input  logic                            tb_rst,
    input  logic                            start,
    input  logic                            feat_valid,
    input  logic [DATA_WIDTH-1:0]           feat_data,
    output logic                            feat_ready,
    output logic [ADDR_WIDTH-1:0]           rom_addr,
    input  logic [DATA_WIDTH-1:0]           rom_data,
    output logic                            busy,
    output logic                            done,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] score,
    output logic                            match
);

    localparam int SW = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;
    localparam logic [SW-1:0] THRESH_W = SW'(THRESH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [SW-1:0]           score_q, score_d;
    logic                    match_q, match_d;
    logic [DATA_WIDTH:0]     abs_diff;

    always_comb begin
        if (feat_data >= rom_data) begin
            abs_diff = {1'b0, feat_data} - {1'b0, rom_data};
        end else begin
            abs_diff = {1'b0, rom_data} - {1'b0, feat_data};
        end
`ifdef TEMPLATE_SCORE_MASK_EN
        if (rom_data == {DATA_WIDTH{1'b1}}) begin
            abs_diff = '0;
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        score_d    = score_q;
        match_d    = match_q;
        feat_ready = 1'b0;
        rom_addr   = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    score_d = '0;
                    match_d = 1'b0;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                busy       = 1'b1;
                feat_ready = 1'b1;
                rom_addr   = idx_q;
                if (feat_valid) begin
                    score_d = score_q + SW'(abs_diff);
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        match_d = (score_d <= THRESH_W);
                    end else begin
                        // Prefetch the next template byte so rom_data lines up with the next feature.
                        rom_addr = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            score_q <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            score_q <= score_d;
            match_q <= match_d;
        end
    end

    assign score = score_q;
    assign match = match_q;

endmodule

// File: tb/tb_fruit_template_scorer.sv
// tb/tb_fruit_template_scorer.sv - self-checking bench for fruit_template_scorer
module tb_fruit_template_scorer;

    localparam int AW     = 11;
    localparam int DW     = 8;
    localparam int SW     = AW + DW;
    localparam int N      = 2 ** AW;
    localparam int THRESH = 16384;
    localparam int MAXC   = 3 * N + 64;
`ifdef TEMPLATE_SCORE_MASK_EN
    localparam int MASK_SCORE = 16384;
`else
    localparam int MASK_SCORE = 277504;
`endif

    logic          clk = 1'b0;
    logic          tb_rst = 1'b1;
    logic          start = 1'b0;
    logic          feat_valid = 1'b0;
    logic [DW-1:0] feat_data = '0;
    logic          feat_ready;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          busy;
    logic          done;
    logic [SW-1:0] score;
    logic          match;

    always #5 clk = ~clk;

    fruit_template_scorer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .THRESH(THRESH)) dut (
        .clk        (clk),
        .tb_rst     (tb_rst),
        .start      (start),
        .feat_valid (feat_valid),
        .feat_data  (feat_data),
        .feat_ready (feat_ready),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .busy       (busy),
        .done       (done),
        .score      (score),
        .match      (match)
    );

    logic [DW-1:0] rom_mem [N];
    logic [DW-1:0] feat_mem[N];
    bit            vseq    [MAXC];

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // rp: 0 identity, 1 zeros, 2 0x10, 3 0xFF/0x10 alternating, 4 feature plus random offset
    // fp: 0 identity, 1 0xFF, 2 zeros, 3 random
    task automatic fill(input int rp, input int fp, input int spread);
        for (int i = 0; i < N; i++) begin
            case (fp)
                0:       feat_mem[i] = 8'(i);
                1:       feat_mem[i] = 8'hFF;
                2:       feat_mem[i] = 8'h00;
                default: feat_mem[i] = 8'($urandom);
            endcase
            case (rp)
                0:       rom_mem[i] = 8'(i);
                1:       rom_mem[i] = 8'h00;
                2:       rom_mem[i] = 8'h10;
                3:       rom_mem[i] = (i % 2 == 0) ? 8'hFF : 8'h10;
                default: rom_mem[i] = 8'(int'(feat_mem[i]) + int'($urandom_range(0, spread)));
            endcase
        end
    endtask

    task automatic gen_valid(input int vmode);
        for (int c = 0; c < MAXC; c++) begin
            case (vmode)
                0:       vseq[c] = 1'b1;
                1:       vseq[c] = (c % 2 == 1);
                default: vseq[c] = ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    function automatic int model_score();
        int sum = 0;
        for (int i = 0; i < N; i++) begin
            int t = int'(rom_mem[i]);
            int f = int'(feat_mem[i]);
            int d = (f > t) ? f - t : t - f;
`ifdef TEMPLATE_SCORE_MASK_EN
            if (t == 255) d = 0;
`endif
            sum += d;
        end
        return sum;
    endfunction

    // The first RUN cycle is one cycle after start; done follows the N-th accepted element.
    function automatic int model_lat();
        int cnt = 0;
        for (int c = 1; c < MAXC; c++) begin
            if (vseq[c]) cnt++;
            if (cnt == N) return c + 1;
        end
        return -1;
    endfunction

    task automatic run_pass(input int restart_at, input int abort_at, input bit start_in_done,
                            output int lat, output int fires, output int stall_bad,
                            output logic [SW-1:0] sc, output logic mt);
        int cyc;
        bit restarted = 0;
        bit dseen;
        lat = -1; fires = 0; stall_bad = 0; sc = '0; mt = 1'b0;
        @(negedge clk);
        start = 1'b1; feat_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < MAXC) begin
            #1;
            if (done) begin
                lat = cyc; sc = score; mt = match;
                break;
            end
            if (abort_at >= 0 && fires == abort_at) begin
                tb_rst = 1'b1; feat_valid = 1'b0; start = 1'b0;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_score", score, 0);
                chk("abort_match", match, 0);
                chk("abort_feat_ready", feat_ready, 0);
                chk("abort_rom_addr", rom_addr, 0);
                @(negedge clk);
                tb_rst = 1'b0;
                dseen = 0;
                repeat (20) begin
                    @(negedge clk); #1;
                    if (done || busy) dseen = 1;
                end
                chk("abort_no_done", dseen, 0);
                return;
            end
            feat_valid = vseq[cyc];
            feat_data  = (fires < N) ? feat_mem[fires] : 8'h00;
            start      = 1'b0;
            if (restart_at >= 0 && fires == restart_at && !restarted) begin
                start = 1'b1; restarted = 1;
            end
            #1;
            if (feat_ready && !feat_valid) begin
                if (rom_addr != AW'(fires) || rom_data != rom_mem[fires]) stall_bad++;
            end
            if (feat_valid && feat_ready) fires++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; feat_valid = 1'b0;
        if (start_in_done && lat >= 0) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("start_in_done_ignored", busy, 0);
            chk("score_hold", score, sc);
            chk("match_hold", match, mt);
        end
    endtask

    typedef struct {
        int rp; int fp; int vmode; int restart_at; bit start_in_done;
        int exp_score; bit exp_match; int exp_lat;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int lat, fires, sbad, rbad, es;
        logic [SW-1:0] sc;
        logic mt;
        int spreads[3];

        tbl[0] = '{0, 0, 0, -1, 1'b1, 0,          1'b1, 2049};
        tbl[1] = '{1, 1, 0, -1, 1'b0, 522240,     1'b0, 2049};
        tbl[2] = '{0, 0, 1, -1, 1'b0, 0,          1'b1, 4096};
        tbl[3] = '{3, 2, 0, -1, 1'b0, MASK_SCORE, (MASK_SCORE <= THRESH), 2049};
        tbl[4] = '{0, 0, 0, 500, 1'b0, 0,         1'b1, 2049};
        spreads = '{255, 12, 30};

        fill(0, 0, 0);
        rbad = 0;
        repeat (20) begin
            @(negedge clk);
            start = 1'($urandom); feat_valid = 1'($urandom); feat_data = 8'($urandom);
            #1;
            if (busy || done || feat_ready || match || rom_addr != 0 || score != 0) rbad++;
        end
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_feat_ready", feat_ready, 0);
        chk("reset_rom_addr", rom_addr, 0);
        chk("reset_score", score, 0);
        chk("reset_match", match, 0);
        chk("reset_all_cycles", rbad, 0);
        @(negedge clk);
        tb_rst = 1'b0; start = 1'b0; feat_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_after_reset", busy, 0);

        for (int k = 0; k < 5; k++) begin
            fill(tbl[k].rp, tbl[k].fp, 0);
            gen_valid(tbl[k].vmode);
            run_pass(tbl[k].restart_at, -1, tbl[k].start_in_done, lat, fires, sbad, sc, mt);
            chk($sformatf("vec%0d_score", k), sc, tbl[k].exp_score);
            chk($sformatf("vec%0d_match", k), mt, tbl[k].exp_match);
            chk($sformatf("vec%0d_latency", k), lat, tbl[k].exp_lat);
            chk($sformatf("vec%0d_fires", k), fires, N);
            chk($sformatf("vec%0d_stall_stable", k), sbad, 0);
        end

        fill(0, 0, 0);
        gen_valid(0);
        run_pass(-1, 1000, 1'b0, lat, fires, sbad, sc, mt);
        fill(2, 2, 0);
        run_pass(-1, -1, 1'b0, lat, fires, sbad, sc, mt);
        chk("after_abort_score", sc, 32768);
        chk("after_abort_match", mt, 0);
        chk("after_abort_latency", lat, 2049);
        chk("after_abort_fires", fires, N);

        for (int r = 0; r < 3; r++) begin
            fill(4, 3, spreads[r]);
            gen_valid(2);
            es = model_score();
            run_pass(-1, -1, 1'b0, lat, fires, sbad, sc, mt);
            chk($sformatf("rand%0d_score", r), sc, es);
            chk($sformatf("rand%0d_match", r), mt, (es <= THRESH));
            chk($sformatf("rand%0d_latency", r), lat, model_lat());
            chk($sformatf("rand%0d_fires", r), fires, N);
            chk($sformatf("rand%0d_stall_stable", r), sbad, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
